// File: rtl/wb_arbiter_decoder.sv
// Two-master, two-slave Wishbone arbiter and address decoder.
// Round-robin grant, per-slave strobes, decode error and ack timeout.
`timescale 1ns/1ps
module wb_arbiter_decoder #(
  parameter logic [31:0] S0_BASE = 32'h0300_0000,
  parameter logic [31:0] S0_MASK = 32'hFFF0_0000,
  parameter logic [31:0] S1_BASE = 32'h0310_0000,
  parameter logic [31:0] S1_MASK = 32'hFFF0_0000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s0_stb_o,
  input  logic        s0_ack_i,
  input  logic [31:0] s0_dat_i,
  output logic        s1_stb_o,
  input  logic        s1_ack_i,
  input  logic [31:0] s1_dat_i
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        rr_q, rr_d, gnt_q, gnt_d, slv_q, slv_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        s_cyc_q, s_cyc_d, s0_stb_q, s0_stb_d, s1_stb_q, s1_stb_d;
  logic        s_we_q, s_we_d;
  logic [3:0]  s_sel_q, s_sel_d;
  logic [31:0] s_adr_q, s_adr_d, s_dat_q, s_dat_d;
  logic        m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
  logic        m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
  logic [31:0] m0_dat_q, m0_dat_d, m1_dat_q, m1_dat_d;

  logic        req0, req1, pick, hit0, hit1, gnt_cyc, ack_sel;
  logic [31:0] adr_in, rdat;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  // With both requesting, the master not pointed at by rr wins.
  assign pick    = (req0 & req1) ? ~rr_q : req1;
  assign adr_in  = pick ? m1_adr_i : m0_adr_i;
  assign hit0    = (adr_in & S0_MASK) == S0_BASE;
  assign hit1    = (adr_in & S1_MASK) == S1_BASE;
  assign gnt_cyc = gnt_q ? m1_cyc_i : m0_cyc_i;
  assign ack_sel = slv_q ? s1_ack_i : s0_ack_i;
  assign rdat    = slv_q ? s1_dat_i : s0_dat_i;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    slv_d    = slv_q;
    tmo_d    = tmo_q;
    s_cyc_d  = s_cyc_q;
    s0_stb_d = s0_stb_q;
    s1_stb_d = s1_stb_q;
    s_we_d   = s_we_q;
    s_sel_d  = s_sel_q;
    s_adr_d  = s_adr_q;
    s_dat_d  = s_dat_q;
    m0_ack_d = 1'b0;
    m0_err_d = 1'b0;
    m1_ack_d = 1'b0;
    m1_err_d = 1'b0;
    m0_dat_d = m0_dat_q;
    m1_dat_d = m1_dat_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          if (req0 & req1) rr_d = pick;
          gnt_d   = pick;
          s_adr_d = adr_in;
          s_dat_d = pick ? m1_dat_i : m0_dat_i;
          s_we_d  = pick ? m1_we_i  : m0_we_i;
          s_sel_d = pick ? m1_sel_i : m0_sel_i;
          tmo_d   = '0;
          if (hit0 | hit1) begin
            s_cyc_d  = 1'b1;
            s0_stb_d = hit0;
            s1_stb_d = ~hit0;
            slv_d    = ~hit0;
            state_d  = BUSY;
          end else begin
            m0_err_d = ~pick;
            m1_err_d = pick;
            state_d  = RESP;
          end
        end
      end
      BUSY: begin
        if (!gnt_cyc || ack_sel || tmo_q == TMO_LAST) begin
          s_cyc_d  = 1'b0;
          s0_stb_d = 1'b0;
          s1_stb_d = 1'b0;
        end
        // An abandoned cycle is dropped silently; ack outranks timeout.
        if (!gnt_cyc) begin
          tmo_d   = '0;
          state_d = IDLE;
        end else if (ack_sel) begin
          m0_ack_d = ~gnt_q;
          m1_ack_d = gnt_q;
          if (gnt_q) m1_dat_d = s_we_q ? '0 : rdat;
          else       m0_dat_d = s_we_q ? '0 : rdat;
          state_d = RESP;
        end else if (tmo_q == TMO_LAST) begin
          m0_err_d = ~gnt_q;
          m1_err_d = gnt_q;
          state_d  = RESP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      RESP: begin
        tmo_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      gnt_q    <= 1'b0;
      slv_q    <= 1'b0;
      tmo_q    <= '0;
      s_cyc_q  <= 1'b0;
      s0_stb_q <= 1'b0;
      s1_stb_q <= 1'b0;
      s_we_q   <= 1'b0;
      s_sel_q  <= '0;
      s_adr_q  <= '0;
      s_dat_q  <= '0;
      m0_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m1_err_q <= 1'b0;
      m0_dat_q <= '0;
      m1_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      slv_q    <= slv_d;
      tmo_q    <= tmo_d;
      s_cyc_q  <= s_cyc_d;
      s0_stb_q <= s0_stb_d;
      s1_stb_q <= s1_stb_d;
      s_we_q   <= s_we_d;
      s_sel_q  <= s_sel_d;
      s_adr_q  <= s_adr_d;
      s_dat_q  <= s_dat_d;
      m0_ack_q <= m0_ack_d;
      m0_err_q <= m0_err_d;
      m1_ack_q <= m1_ack_d;
      m1_err_q <= m1_err_d;
      m0_dat_q <= m0_dat_d;
      m1_dat_q <= m1_dat_d;
    end
  end

  assign s_cyc_o  = s_cyc_q;
  assign s0_stb_o = s0_stb_q;
  assign s1_stb_o = s1_stb_q;
  assign s_we_o   = s_we_q;
  assign s_sel_o  = s_sel_q;
  assign s_adr_o  = s_adr_q;
  assign s_dat_o  = s_dat_q;
  assign m0_ack_o = m0_ack_q;
  assign m0_err_o = m0_err_q;
  assign m0_dat_o = m0_dat_q;
  assign m1_ack_o = m1_ack_q;
  assign m1_err_o = m1_err_q;
  assign m1_dat_o = m1_dat_q;

endmodule

// File: tb/tb_wb_arbiter_decoder.sv
// Directed bench for wb_arbiter_decoder: transfers, round-robin, decode error,
// timeout and reset abort, with hand-computed expectations.
`timescale 1ns/1ps
module tb_wb_arbiter_decoder;

  logic        clk = 1'b0, rst = 1'b1;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [3:0]  m0_sel = '0;
  logic [31:0] m0_adr = '0, m0_wdat = '0;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdat;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]  m1_sel = '0;
  logic [31:0] m1_adr = '0, m1_wdat = '0;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdat;
  logic        s_cyc, s_we, s0_stb, s1_stb;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat;
  logic        s0_ack = 0, s1_ack = 0;
  logic [31:0] s0_dat = '0, s1_dat = '0;

  int unsigned total = 0, bad = 0;
  logic        seen;

  always #5 clk = ~clk;

  wb_arbiter_decoder #(
    .S0_BASE(32'h0300_0000), .S0_MASK(32'hFFF0_0000),
    .S1_BASE(32'h0310_0000), .S1_MASK(32'hFFF0_0000), .TIMEOUT(255)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_dat),
    .s0_stb_o(s0_stb), .s0_ack_i(s0_ack), .s0_dat_i(s0_dat),
    .s1_stb_o(s1_stb), .s1_ack_i(s1_ack), .s1_dat_i(s1_dat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_cyc", {31'b0, s_cyc}, 0);
    chk("rst_stb", {30'b0, s0_stb, s1_stb}, 0);
    chk("rst_m0", {30'b0, m0_ack, m0_err}, 0);
    chk("rst_m1", {30'b0, m1_ack, m1_err}, 0);
    chk("rst_adr", s_adr, 0);
    rst = 1'b0;
    tick();

    // m0 write to slave 0, acked two cycles after stb
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
    m0_adr = 32'h0300_0000; m0_wdat = 32'h0000_00A5;
    tick();
    chk("wr_s0stb", {31'b0, s0_stb}, 1);
    chk("wr_s1stb", {31'b0, s1_stb}, 0);
    chk("wr_cyc", {31'b0, s_cyc}, 1);
    chk("wr_adr", s_adr, 32'h0300_0000);
    chk("wr_dat", s_dat, 32'h0000_00A5);
    chk("wr_we_sel", {27'b0, s_we, s_sel}, 32'h1F);
    tick();
    chk("wr_noack", {31'b0, m0_ack}, 0);
    tick();
    s0_ack = 1; s0_dat = 32'h1234_5678;
    tick();
    chk("wr_ack", {31'b0, m0_ack}, 1);
    chk("wr_rdat0", m0_rdat, 0);
    chk("wr_drop", {29'b0, s_cyc, s0_stb, s1_stb}, 0);
    s0_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
    tick();
    chk("wr_ackpulse", {31'b0, m0_ack}, 0);
    tick();

    // m1 read from slave 1
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0310_0004;
    tick();
    chk("rd_stb", {30'b0, s0_stb, s1_stb}, 32'h1);
    s1_ack = 1; s1_dat = 32'hDEAD_BEEF;
    tick();
    chk("rd_ack", {31'b0, m1_ack}, 1);
    chk("rd_dat", m1_rdat, 32'hDEAD_BEEF);
    chk("rd_m0quiet", {30'b0, m0_ack, m0_err}, 0);
    s1_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();
    chk("rd_hold", m1_rdat, 32'hDEAD_BEEF);

    // Round-robin: both request for three rounds, expect m1, m0, m1
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0300_0000;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0310_0000;
    tick();
    chk("rr1_gnt", s_adr, 32'h0310_0000);
    s1_ack = 1; s1_dat = 32'h0000_0011;
    tick();
    chk("rr1_ack", {30'b0, m0_ack, m1_ack}, 32'h1);
    s1_ack = 0;
    tick();
    chk("rr1_resp", {30'b0, m0_ack, m1_ack}, 0);
    tick();
    chk("rr2_gnt", {30'b0, s0_stb, s1_stb}, 32'h2);
    s0_ack = 1; s0_dat = 32'h0000_0022;
    tick();
    chk("rr2_ack", {30'b0, m0_ack, m1_ack}, 32'h2);
    chk("rr2_dat", m0_rdat, 32'h0000_0022);
    s0_ack = 0;
    tick(); tick();
    chk("rr3_gnt", {30'b0, s0_stb, s1_stb}, 32'h1);
    s1_ack = 1; s1_dat = 32'h0000_0033;
    tick();
    chk("rr3_ack", {30'b0, m0_ack, m1_ack}, 32'h1);
    chk("rr3_dat", m1_rdat, 32'h0000_0033);
    s1_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();

    // Decode miss
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0400_0000;
    tick();
    chk("miss_err", {31'b0, m0_err}, 1);
    chk("miss_cyc", {29'b0, s_cyc, s0_stb, s1_stb}, 0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("miss_pulse", {31'b0, m0_err}, 0);
    tick();

    // Timeout on slave 0 with a stray slave 1 ack present throughout
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0300_0010; s1_ack = 1;
    tick();
    chk("tmo_stb", {31'b0, s0_stb}, 1);
    seen = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      seen = seen | m0_ack | m0_err | ~s_cyc;
    end
    chk("tmo_early", {31'b0, seen}, 0);
    tick();
    chk("tmo_err", {31'b0, m0_err}, 1);
    chk("tmo_noack", {31'b0, m0_ack}, 0);
    chk("tmo_drop", {30'b0, s_cyc, s0_stb}, 0);
    m0_cyc = 0; m0_stb = 0; s1_ack = 0;
    tick();
    chk("tmo_pulse", {31'b0, m0_err}, 0);
    tick();

    // Reset during BUSY, then a fresh read completes
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h0300_0000; m0_wdat = 32'h5;
    tick();
    chk("ab_busy", {31'b0, s0_stb}, 1);
    rst = 1; s0_ack = 1;
    tick();
    chk("ab_out", {27'b0, s_cyc, s0_stb, s1_stb, m0_ack, m0_err}, 0);
    chk("ab_adr", s_adr, 0);
    rst = 0; s0_ack = 0; m0_we = 0;
    tick();
    chk("ab_regrant", {30'b0, s_cyc, s0_stb}, 32'h3);
    chk("ab_noack", {30'b0, m0_ack, m0_err}, 0);
    s0_ack = 1; s0_dat = 32'hCAFE_0001;
    tick();
    chk("ab_ack", {31'b0, m0_ack}, 1);
    chk("ab_dat", m0_rdat, 32'hCAFE_0001);
    s0_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_decoder.md
Name: wb_arbiter_decoder

Overview:
- Wishbone arbiter and address decoder between two bus masters and two slave regions.
  - Master 0: the picosoc iomem-to-wishbone bridge.
  - Master 1: a second requester, e.g. a debug or DMA master.
  - Slave 0: LED/button peripheral. Slave 1: multi-project harness.
- Replaces the OR-ed ack/data fan-in with explicit per-slave strobes, round-robin grant, decode error and bus timeout.
- Single clock domain.

Parameters:
- S0_BASE, 32'h0300_0000, base address of slave 0 region.
- S0_MASK, 32'hFFF0_0000, compare mask for slave 0.
- S1_BASE, 32'h0310_0000, base address of slave 1 region.
- S1_MASK, 32'hFFF0_0000, compare mask for slave 1.
- TIMEOUT, 255, cycles allowed for a slave ack before error (1..255, 8-bit counter).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- mN_cyc_i, mN_stb_i, mN_we_i  in  1 each  master N cycle/strobe/write (N = 0,1)
- mN_sel_i  in  4  master N byte select
- mN_adr_i, mN_dat_i  in  32 each  master N address / write data
- mN_ack_o, mN_err_o  out  1 each  master N ack / error, single-cycle pulses
- mN_dat_o  out  32  master N read data, valid with mN_ack_o
- s_cyc_o, s_we_o  out  1 each  shared slave cycle / write enable
- s_sel_o  out  4  shared byte select
- s_adr_o, s_dat_o  out  32 each  shared address / write data
- sK_stb_o  out  1  per-slave strobe (K = 0,1)
- sK_ack_i  in  1  slave K ack
- sK_dat_i  in  32  slave K read data

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer = 0 (master 0 preferred), timeout counter 0. Reset mid-transfer clears all outputs on the next edge; no ack or err is issued for the aborted transfer.
- Request: mN_cyc_i & mN_stb_i.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay.
  - One request: grant it.
  - Both requesting: grant the master != rr; rr then toggles to point at the granted master.
  - On grant, latch adr/dat/we/sel into the s_* registers and decode:
    - hit0 = (adr & S0_MASK) == S0_BASE; hit1 likewise; slave 0 wins if both hit.
    - Hit: s_cyc_o = 1 and the selected sK_stb_o = 1 on the next edge (latency 1); go to BUSY.
    - No hit: no slave cycle; pulse mN_err_o on the next edge; go to RESP.
- BUSY:
  - Only the selected slave's ack counts; an ack from the other slave is ignored.
  - Selected ack in cycle K: at edge K+1, mN_ack_o = 1 for one cycle, mN_dat_o = sK_dat_i (0 on writes), s_cyc_o/sK_stb_o = 0; go to RESP.
  - Timeout counter increments each BUSY cycle without ack. Reaching TIMEOUT: pulse mN_err_o, drop cyc/stb, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
  - Granted master drops mN_cyc_i: drop cyc/stb next edge, return to IDLE, no ack/err.
- RESP: one cycle; ack/err deasserts; counter cleared; go to IDLE. This stops a stale stb from re-granting. Earliest next grant is K+2.
- The non-granted master sees ack/err = 0 and is held pending; it is granted at the next IDLE.
- mN_dat_o holds its value until the next ack to that master.

Test Plan:
- m0 write 0x0000_00A5 to 0x0300_0000, sel=4'hF; slave 0 acks 2 cycles after stb -> s0_stb_o high 1 cycle after request; m0_ack_o one-cycle pulse 1 cycle after s0_ack_i; s1_stb_o never asserts.
- m1 read 0x0310_0004; slave 1 returns 0xDEAD_BEEF -> m1_dat_o = 0xDEAD_BEEF with m1_ack_o; m0 outputs stay 0.
- m0 and m1 request simultaneously, three back-to-back rounds after reset -> grant order m1, m0, m1 (rr starts at 0); each gets exactly one ack.
- m0 accesses 0x0400_0000 -> m0_err_o pulses 1 cycle after request; s_cyc_o stays 0.
- m0 accesses 0x0300_0010 with slave never acking, TIMEOUT=255 -> m0_err_o pulses after 255 BUSY cycles; s_cyc_o drops the same edge. Separately, s1_ack_i asserted during this access -> ignored.
- wb_rst_i asserted 1 cycle during BUSY -> all outputs 0 next edge, no ack/err; a fresh m0 request afterwards completes normally.
